fsm_step_sched: RTL and testbench

Step scheduler that sequences the lab's mod-6 state counter from the DE2 board inputs. It replaces the raw switch-as-clock scheme. A synchronised, edge-detected push-button and a prescaled free-run tick are merged into single-cycle step enables on CLOCK_50. A one-shot mode stops the counter after one full lap. The block sits between board I/O and the counter datapath, which consumes `step_en`/`clr` and returns its terminal flag `tc`.

---
 rtl/fsm_step_pkg.sv | 36 +++
 rtl/sync_edge.sv | 47 ++++
 rtl/fsm_step_sched.sv | 180 ++++++++++++++++++
 tb/tb_fsm_step_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_step_pkg.sv
// ---------------------------------------------------------------------------
// fsm_step_pkg
// Shared types and constants for the step scheduler.
//   state_t   : scheduler state enum (IDLE, RUN, SINGLE, DONE)
//   LEDG_*    : one-hot LEDG codes, one per state
//   ledgOf()  : maps a state to its LEDG code; unknown encodings show IDLE
// ---------------------------------------------------------------------------
package fsm_step_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_SINGLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] LEDG_IDLE   = 4'b0001;
   localparam logic [3:0] LEDG_RUN    = 4'b0010;
   localparam logic [3:0] LEDG_SINGLE = 4'b0100;
   localparam logic [3:0] LEDG_DONE   = 4'b1000;

   // The LEDG pattern is a pure function of the state, so the FSM can
   // register it from the next-state value and keep it in step with state_q.
   function automatic logic [3:0] ledgOf(input state_t s);
      logic [3:0] code;
      case (s)
         ST_IDLE:   code = LEDG_IDLE;
         ST_RUN:    code = LEDG_RUN;
         ST_SINGLE: code = LEDG_SINGLE;
         ST_DONE:   code = LEDG_DONE;
         default:   code = LEDG_IDLE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Multi-flop synchroniser for one asynchronous input, followed by a history
// flop that turns level changes of the synchronised value into one-cycle
// rise/fall pulses.
//   clk_i    : sampling clock
//   rst_ni   : asynchronous active-low reset; chain and history take RESET_VAL
//   d_i      : asynchronous input
//   level_o  : synchronised level (last chain stage)
//   rise_o   : one-cycle pulse on a synchronised 0->1 transition
//   fall_o   : one-cycle pulse on a synchronised 1->0 transition
// ---------------------------------------------------------------------------
module sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] chain_q;
   logic                   prev_q;

   // Shift the raw input through the chain; prev_q holds the previous
   // synchronised value so edges can be seen one cycle after they settle.
   // Resetting to RESET_VAL keeps a released button (idle high) from looking
   // like a press right after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chain_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q  <= RESET_VAL;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
         prev_q  <= chain_q[SYNC_STAGES-1];
      end
   end

   // Edge pulses compare the settled value against last cycle's value.
   assign level_o = chain_q[SYNC_STAGES-1];
   assign rise_o  = chain_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_o  = ~chain_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/fsm_step_sched.sv
// ---------------------------------------------------------------------------
// fsm_step_sched
// Step scheduler for the mod-6 lab counter. Merges a synchronised,
// edge-detected push-button and a prescaled free-running tick into
// single-cycle step enables on CLOCK_50, with clear and one-shot lap modes.
//   CLOCK_50  : system clock
//   KEY[0]    : asynchronous active-low reset
//   KEY[1]    : manual step button, active-low, asynchronous
//   SW[0]     : run enable
//   SW[1]     : one-shot mode (stop after the lap that wraps the counter)
//   SW[2]     : clear request (acts on its synchronised rising edge)
//   tc        : counter terminal flag (counter sitting in s5)
//   step_en   : one-cycle advance pulse to the counter
//   clr       : one-cycle clear pulse to the counter
//   busy      : high while in RUN
//   LEDG[3:0] : one-hot state display {DONE, SINGLE, RUN, IDLE}
// ---------------------------------------------------------------------------
module fsm_step_sched
   import fsm_step_pkg::*;
#(
   parameter int PRESCALE    = 50_000_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLOCK_50,
   input  logic [1:0] KEY,
   input  logic [2:0] SW,
   input  logic       tc,
   output logic       step_en,
   output logic       clr,
   output logic       busy,
   output logic [3:0] LEDG
);

   localparam int             PSC_W   = $clog2(PRESCALE);
   localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

   logic rst_n;
   assign rst_n = KEY[0];

   // Button and clear request need edge pulses, so they get the full
   // synchroniser-with-edge-detect. The button idles high.
   logic keyLevel, keyRise, keyFall;
   logic clrLevel, clrRise, clrFall;

   sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (1'b1)
   ) u_keySync (
      .clk_i   (CLOCK_50),
      .rst_ni  (rst_n),
      .d_i     (KEY[1]),
      .level_o (keyLevel),
      .rise_o  (keyRise),
      .fall_o  (keyFall)
   );

   sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (1'b0)
   ) u_clrSync (
      .clk_i   (CLOCK_50),
      .rst_ni  (rst_n),
      .d_i     (SW[2]),
      .level_o (clrLevel),
      .rise_o  (clrRise),
      .fall_o  (clrFall)
   );

   logic unusedSyncOutputs;
   assign unusedSyncOutputs = &{1'b0, keyLevel, keyRise, clrLevel, clrFall};

   // Run and one-shot switches are only used as levels, so plain chains.
   logic [SYNC_STAGES-1:0] runSync_q;
   logic [SYNC_STAGES-1:0] oneShotSync_q;
   logic                   runOn;
   logic                   oneShotOn;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         runSync_q     <= '0;
         oneShotSync_q <= '0;
      end else begin
         runSync_q     <= {runSync_q[SYNC_STAGES-2:0], SW[0]};
         oneShotSync_q <= {oneShotSync_q[SYNC_STAGES-2:0], SW[1]};
      end
   end

   assign runOn     = runSync_q[SYNC_STAGES-1];
   assign oneShotOn = oneShotSync_q[SYNC_STAGES-1];

   state_t           state_q, state_d;
   logic [PSC_W-1:0] psc_q, psc_d;
   logic             tick_q, tick_d;
   logic             stepEn_q, stepEn_d;
   logic             clr_q, clr_d;
   logic             busy_q;
   logic [3:0]       ledg_q;

   // Next-state logic. Clear wins over everything and suppresses any step
   // in the same cycle. The prescale tick is registered (tick_q) so tc is
   // sampled in the cycle before step_en; the prescaler only advances while
   // the FSM stays in RUN, so it is zero on every RUN entry.
   always_comb begin
      state_d  = state_q;
      psc_d    = '0;
      tick_d   = 1'b0;
      stepEn_d = 1'b0;
      clr_d    = 1'b0;
      if (clrRise) begin
         clr_d   = 1'b1;
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (keyFall) begin
                  state_d = ST_SINGLE;
               end else if (runOn) begin
                  state_d = ST_RUN;
               end
            end
            ST_SINGLE: begin
               stepEn_d = 1'b1;
               state_d  = ST_IDLE;
            end
            ST_RUN: begin
               if (!runOn) begin
                  state_d = ST_IDLE;
               end else begin
                  if (tick_q) begin
                     stepEn_d = 1'b1;
                     if (tc && oneShotOn) begin
                        state_d = ST_DONE;
                     end
                  end
                  if (state_d == ST_RUN) begin
                     tick_d = (psc_q == PSC_MAX);
                     psc_d  = (psc_q == PSC_MAX) ? '0 : psc_q + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (!runOn) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and every output are registered together; LEDG and busy are
   // derived from the next state so they change on the same edge as state_q.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         psc_q    <= '0;
         tick_q   <= 1'b0;
         stepEn_q <= 1'b0;
         clr_q    <= 1'b0;
         busy_q   <= 1'b0;
         ledg_q   <= LEDG_IDLE;
      end else begin
         state_q  <= state_d;
         psc_q    <= psc_d;
         tick_q   <= tick_d;
         stepEn_q <= stepEn_d;
         clr_q    <= clr_d;
         busy_q   <= (state_d == ST_RUN);
         ledg_q   <= ledgOf(state_d);
      end
   end

   assign step_en = stepEn_q;
   assign clr     = clr_q;
   assign busy    = busy_q;
   assign LEDG    = ledg_q;

endmodule

// File: tb/tb_fsm_step_sched.sv
// ---------------------------------------------------------------------------
// tb_fsm_step_sched
// Directed bench for the step scheduler with PRESCALE=4, SYNC_STAGES=2.
// A small mod-6 counter model consumes step_en/clr and drives tc back.
// Inputs change and outputs are sampled on the falling clock edge; the
// window index k counts falling edges since the last stimulus mark, so
// k equals the number of rising edges since the new input was first sampled.
// ---------------------------------------------------------------------------
module tb_fsm_step_sched;

   logic       CLOCK_50;
   logic [1:0] key;
   logic [2:0] sw;
   logic       tc;
   logic       step_en;
   logic       clr;
   logic       busy;
   logic [3:0] LEDG;

   int compareCount;
   int mismatchCount;
   int k;
   int bothHigh;
   int pulses[$];
   int clrs[$];
   logic [2:0] cnt;

   fsm_step_sched #(
      .PRESCALE    (4),
      .SYNC_STAGES (2)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .KEY      (key),
      .SW       (sw),
      .tc       (tc),
      .step_en  (step_en),
      .clr      (clr),
      .busy     (busy),
      .LEDG     (LEDG)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   // Mod-6 counter datapath model; tc is high while it sits in s5.
   always @(posedge CLOCK_50 or negedge key[0]) begin
      if (!key[0]) begin
         cnt <= 3'd0;
      end else if (clr) begin
         cnt <= 3'd0;
      end else if (step_en) begin
         cnt <= (cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
      end
   end

   assign tc = (cnt == 3'd5);

   // Hard stop in case something wedges the stimulus.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] swVal, input logic key1);
      sw     = swVal;
      key[1] = key1;
   endtask

   task automatic startWindow();
      k = 0;
      pulses.delete();
      clrs.delete();
   endtask

   task automatic waitCycle();
      @(negedge CLOCK_50);
      k++;
      if (step_en === 1'b1) pulses.push_back(k);
      if (clr === 1'b1) clrs.push_back(k);
      if (step_en === 1'b1 && clr === 1'b1) bothHigh++;
   endtask

   function automatic int pulseAt(input int i);
      return (pulses.size() > i) ? pulses[i] : -1;
   endfunction

   function automatic int clrAt(input int i);
      return (clrs.size() > i) ? clrs[i] : -1;
   endfunction

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      bothHigh      = 0;
      k             = 0;
      key           = 2'b10;
      sw            = 3'b000;

      // Power-on reset values
      repeat (3) waitCycle();
      checkOutput("rstLedg", int'(LEDG), 1);
      checkOutput("rstStep", int'(step_en), 0);
      checkOutput("rstClr", int'(clr), 0);
      checkOutput("rstBusy", int'(busy), 0);
      key[0] = 1'b1;
      repeat (3) waitCycle();

      // Manual step: held button gives one pulse, 4 edges after first low sample
      startWindow();
      applyStimulus(3'b000, 1'b0);
      repeat (3) waitCycle();
      checkOutput("manSingleLedg", int'(LEDG), 4);
      repeat (7) waitCycle();
      applyStimulus(3'b000, 1'b1);
      repeat (4) waitCycle();
      checkOutput("manPulseCount", pulses.size(), 1);
      checkOutput("manLatency", pulseAt(0), 4);
      checkOutput("manIdleLedg", int'(LEDG), 1);

      // A second, separate short press gives exactly one more pulse
      startWindow();
      applyStimulus(3'b000, 1'b0);
      repeat (2) waitCycle();
      applyStimulus(3'b000, 1'b1);
      repeat (8) waitCycle();
      checkOutput("man2PulseCount", pulses.size(), 1);
      checkOutput("man2Latency", pulseAt(0), 4);

      // Run cadence: first pulse 5 cycles after LEDG[1] rises, then every 4.
      // SW[0] drops so its synchronised low lands on the 8th tick cycle.
      startWindow();
      applyStimulus(3'b001, 1'b1);
      repeat (3) waitCycle();
      checkOutput("runLedg", int'(LEDG), 2);
      checkOutput("runBusy", int'(busy), 1);
      repeat (30) waitCycle();
      applyStimulus(3'b000, 1'b1);
      repeat (12) waitCycle();
      checkOutput("runPulseCount", pulses.size(), 7);
      for (int i = 0; i < 7; i++) begin
         checkOutput($sformatf("runPulse%0d", i), pulseAt(i), 8 + 4 * i);
      end
      checkOutput("runStopLedg", int'(LEDG), 1);
      checkOutput("runStopBusy", int'(busy), 0);

      // Clear from IDLE: single pulse 3 edges after first sample, held SW[2]
      startWindow();
      applyStimulus(3'b100, 1'b1);
      repeat (8) waitCycle();
      applyStimulus(3'b000, 1'b1);
      repeat (3) waitCycle();
      checkOutput("clrCount", clrs.size(), 1);
      checkOutput("clrLatency", clrAt(0), 3);

      // One-shot lap: six steps, the sixth wraps the counter and enters DONE
      startWindow();
      applyStimulus(3'b011, 1'b1);
      repeat (29) waitCycle();
      checkOutput("osPulseCount", pulses.size(), 6);
      checkOutput("osLastPulse", pulseAt(5), 28);
      checkOutput("osDoneLedg", int'(LEDG), 8);
      checkOutput("osDoneBusy", int'(busy), 0);
      checkOutput("osCounterWrapped", int'(cnt), 0);
      applyStimulus(3'b011, 1'b0);
      repeat (2) waitCycle();
      applyStimulus(3'b011, 1'b1);
      repeat (8) waitCycle();
      checkOutput("osDonePressIgnored", pulses.size(), 6);
      checkOutput("osDoneHeld", int'(LEDG), 8);
      applyStimulus(3'b000, 1'b1);
      repeat (4) waitCycle();
      checkOutput("osExitLedg", int'(LEDG), 1);

      // Clear collides with a RUN tick: clear wins, prescaler restarts
      startWindow();
      applyStimulus(3'b001, 1'b1);
      repeat (9) waitCycle();
      applyStimulus(3'b101, 1'b1);
      repeat (3) waitCycle();
      checkOutput("colClr", int'(clr), 1);
      checkOutput("colStep", int'(step_en), 0);
      checkOutput("colLedg", int'(LEDG), 1);
      checkOutput("colBusy", int'(busy), 0);
      applyStimulus(3'b001, 1'b1);
      waitCycle();
      checkOutput("colReRunLedg", int'(LEDG), 2);

      // Presses during RUN are ignored: steps follow the tick cadence only
      for (int i = 0; i < 4; i++) begin
         applyStimulus(3'b001, 1'b0);
         repeat (3) waitCycle();
         applyStimulus(3'b001, 1'b1);
         repeat (3) waitCycle();
      end
      checkOutput("pressRunCount", pulses.size(), 6);
      checkOutput("colRestartPulse", pulseAt(1), 18);
      checkOutput("pressRunLastPulse", pulseAt(5), 34);

      // Reset asserted mid-RUN takes effect immediately
      #2;
      key[0] = 1'b0;
      #1;
      checkOutput("midRstLedg", int'(LEDG), 1);
      checkOutput("midRstBusy", int'(busy), 0);
      checkOutput("midRstStep", int'(step_en), 0);
      repeat (2) waitCycle();
      key[0] = 1'b1;
      startWindow();
      repeat (6) waitCycle();
      checkOutput("postRstNoStep", pulses.size(), 0);

      checkOutput("stepClrExclusive", bothHigh, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
